// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR frame arbiter: FSM states, grant encoding
// and the frame-buffer base address helper.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

  // Base address of the selected ping-pong buffer.
  function automatic logic [63:0] buf_base(input logic        sel,
                                           input logic [63:0] base0,
                                           input logic [63:0] base1);
    return sel ? base1 : base0;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Per-requester frame walker: tracks the beat offset inside the current frame,
// whether a frame is in progress, a pending frame start, and whether the
// requester may be granted the next burst given its FIFO level.
module frame_addr_gen
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 28,
  parameter int unsigned LVL_W          = 11,
  parameter int unsigned BURST_LEN      = 64,
  parameter int unsigned FRAME_BEATS    = 16320,
  // 1: eligible when level >= LEVEL_THRESH (data waiting to be written)
  // 0: eligible when level <= LEVEL_THRESH (room for a read burst)
  parameter bit          LEVEL_AT_LEAST = 1'b1,
  parameter int unsigned LEVEL_THRESH   = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              apply_i,
  input  logic              advance_i,
  input  logic [LVL_W-1:0]  level_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              pending_o,
  output logic              active_o,
  output logic              frame_full_o,
  output logic              offset_nz_o,
  output logic              eligible_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_BEATS);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  THRESH     = LVL_W'(LEVEL_THRESH);

  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              active_q, active_d;
  logic              pending_q, pending_d;
  logic              level_ok;

  // Next offset/active/pending: a start pulse arriving while an older one is
  // being applied stays pending for the next arbitration slot.
  always_comb begin
    offset_d  = offset_q;
    active_d  = active_q;
    pending_d = start_i | (pending_q & ~apply_i);
    if (apply_i) begin
      offset_d = '0;
      active_d = 1'b1;
    end else if (advance_i && (offset_q < FRAME_END)) begin
      offset_d = offset_q + BURST_STEP;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      offset_q  <= '0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign level_ok     = LEVEL_AT_LEAST ? (level_i >= THRESH) : (level_i <= THRESH);
  assign pending_o    = pending_q;
  assign active_o     = active_q;
  assign frame_full_o = (offset_q == FRAME_END);
  assign offset_nz_o  = (offset_q != '0);
  assign eligible_o   = active_q && (offset_q < FRAME_END) && level_ok;
  assign addr_o       = base_i + offset_q;

endmodule

// File: rtl/ddr_frame_arbiter.sv
// Arbitrates one DDR3 burst command port between the camera write FIFO and
// the display read FIFO, and manages ping-pong frame buffers so the display
// always starts on the most recently completed frame.
module ddr_frame_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 28,
  parameter int unsigned LVL_W         = 11,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned RD_FIFO_DEPTH = 1024,
  parameter int unsigned RD_URGENT     = 128,
  parameter int unsigned FRAME_BEATS   = 16320,
  parameter int unsigned BUF0_BASE     = 0,
  parameter int unsigned BUF1_BASE     = 'h100000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  input  logic              wr_frame_start,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic              rd_frame_start,
  input  logic [LVL_W-1:0]  rd_fifo_level,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_is_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              burst_done,
  output logic              wr_buf_sel,
  output logic              rd_buf_sel,
  output logic              frame_dropped
);

  localparam logic [LVL_W-1:0] URGENT_LVL = LVL_W'(RD_URGENT);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              cmd_is_write_q, cmd_is_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_buf_sel_q, wr_buf_sel_d;
  logic              rd_buf_sel_q, rd_buf_sel_d;
  logic              done_buf_q, done_buf_d;
  logic              frame_dropped_q, frame_dropped_d;

  logic              in_arb, in_wait;
  logic              wr_pending, wr_active, wr_full, wr_offset_nz, wr_eligible;
  logic              rd_pending, rd_active, rd_full, rd_offset_nz, rd_eligible;
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_base, rd_base;
  logic              wr_apply, rd_apply, wr_advance, rd_advance;
  logic              pick_write;
  logic              unused_rd_status;

  assign in_arb     = (state_q == ST_ARB);
  assign in_wait    = (state_q == ST_WAIT);
  assign wr_apply   = in_arb && wr_pending;
  assign rd_apply   = in_arb && rd_pending;
  assign wr_advance = in_wait && burst_done && (last_grant_q == GNT_WR);
  assign rd_advance = in_wait && burst_done && (last_grant_q == GNT_RD);

  assign wr_base = ADDR_W'(buf_base(wr_buf_sel_q, 64'(BUF0_BASE), 64'(BUF1_BASE)));
  assign rd_base = ADDR_W'(buf_base(rd_buf_sel_q, 64'(BUF0_BASE), 64'(BUF1_BASE)));

  frame_addr_gen #(
    .ADDR_W        (ADDR_W),
    .LVL_W         (LVL_W),
    .BURST_LEN     (BURST_LEN),
    .FRAME_BEATS   (FRAME_BEATS),
    .LEVEL_AT_LEAST(1'b1),
    .LEVEL_THRESH  (BURST_LEN)
  ) u_wr_gen (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .start_i     (wr_frame_start),
    .apply_i     (wr_apply),
    .advance_i   (wr_advance),
    .level_i     (wr_fifo_level),
    .base_i      (wr_base),
    .pending_o   (wr_pending),
    .active_o    (wr_active),
    .frame_full_o(wr_full),
    .offset_nz_o (wr_offset_nz),
    .eligible_o  (wr_eligible),
    .addr_o      (wr_addr)
  );

  frame_addr_gen #(
    .ADDR_W        (ADDR_W),
    .LVL_W         (LVL_W),
    .BURST_LEN     (BURST_LEN),
    .FRAME_BEATS   (FRAME_BEATS),
    .LEVEL_AT_LEAST(1'b0),
    .LEVEL_THRESH  (RD_FIFO_DEPTH - BURST_LEN)
  ) u_rd_gen (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .start_i     (rd_frame_start),
    .apply_i     (rd_apply),
    .advance_i   (rd_advance),
    .level_i     (rd_fifo_level),
    .base_i      (rd_base),
    .pending_o   (rd_pending),
    .active_o    (rd_active),
    .frame_full_o(rd_full),
    .offset_nz_o (rd_offset_nz),
    .eligible_o  (rd_eligible),
    .addr_o      (rd_addr)
  );

  // The read side's frame status is not needed when a read frame restarts.
  assign unused_rd_status = &{1'b0, rd_active, rd_full, rd_offset_nz};

  // Winner selection: a starving display FIFO preempts everything, otherwise
  // alternate when both sides want the port.
  always_comb begin
    pick_write = wr_eligible;
    if (rd_eligible && (rd_fifo_level < URGENT_LVL)) begin
      pick_write = 1'b0;
    end else if (wr_eligible && rd_eligible) begin
      pick_write = (last_grant_q == GNT_RD);
    end
  end

  // Next-state logic: frame-start bookkeeping and grants happen only in ARB.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    cmd_is_write_d  = cmd_is_write_q;
    cmd_addr_d      = cmd_addr_q;
    wr_buf_sel_d    = wr_buf_sel_q;
    rd_buf_sel_d    = rd_buf_sel_q;
    done_buf_d      = done_buf_q;
    frame_dropped_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (wr_pending || rd_pending) begin
          if (wr_pending) begin
            if (wr_active && wr_full) begin
              done_buf_d   = wr_buf_sel_q;
              wr_buf_sel_d = ~wr_buf_sel_q;
            end else if (wr_active && wr_offset_nz) begin
              frame_dropped_d = 1'b1;
            end
          end
          // Uses the completed buffer as registered, i.e. before any swap
          // applied in this same cycle.
          if (rd_pending) begin
            rd_buf_sel_d = done_buf_q;
          end
        end else if (Enable && (wr_eligible || rd_eligible)) begin
          cmd_is_write_d = pick_write;
          cmd_addr_d     = pick_write ? wr_addr : rd_addr;
          last_grant_d   = pick_write ? GNT_WR : GNT_RD;
          state_d        = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (burst_done) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Arbiter registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q         <= ST_ARB;
      last_grant_q    <= GNT_RD;
      cmd_is_write_q  <= 1'b0;
      cmd_addr_q      <= '0;
      wr_buf_sel_q    <= 1'b0;
      rd_buf_sel_q    <= 1'b1;
      done_buf_q      <= 1'b1;
      frame_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cmd_is_write_q  <= cmd_is_write_d;
      cmd_addr_q      <= cmd_addr_d;
      wr_buf_sel_q    <= wr_buf_sel_d;
      rd_buf_sel_q    <= rd_buf_sel_d;
      done_buf_q      <= done_buf_d;
      frame_dropped_q <= frame_dropped_d;
    end
  end

  assign cmd_valid     = (state_q == ST_CMD);
  assign cmd_is_write  = cmd_is_write_q;
  assign cmd_addr      = cmd_addr_q;
  assign wr_buf_sel    = wr_buf_sel_q;
  assign rd_buf_sel    = rd_buf_sel_q;
  assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Self-checking bench for ddr_frame_arbiter: directed scenarios followed by
// randomized traffic, each burst checked against a transaction-level model.
module tb_ddr_frame_arbiter;

  localparam int ADDR_W      = 28;
  localparam int LVL_W       = 11;
  localparam int BURST_LEN   = 64;
  localparam int RD_DEPTH    = 1024;
  localparam int RD_URGENT   = 128;
  localparam int FRAME_BEATS = 16320;
  localparam longint BUF0    = 0;
  localparam longint BUF1    = 'h100000;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Enable = 1'b0;
  logic              wr_frame_start = 1'b0;
  logic [LVL_W-1:0]  wr_fifo_level = '0;
  logic              rd_frame_start = 1'b0;
  logic [LVL_W-1:0]  rd_fifo_level = '0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              cmd_is_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              burst_done = 1'b0;
  logic              wr_buf_sel;
  logic              rd_buf_sel;
  logic              frame_dropped;

  ddr_frame_arbiter dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Enable        (Enable),
    .wr_frame_start(wr_frame_start),
    .wr_fifo_level (wr_fifo_level),
    .rd_frame_start(rd_frame_start),
    .rd_fifo_level (rd_fifo_level),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_is_write  (cmd_is_write),
    .cmd_addr      (cmd_addr),
    .burst_done    (burst_done),
    .wr_buf_sel    (wr_buf_sel),
    .rd_buf_sel    (rd_buf_sel),
    .frame_dropped (frame_dropped)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int drop_cnt = 0;
  int txn = 0;
  bit rand_starts = 0;

  // Reference model state (frame-level view of the arbiter)
  bit m_wr_act, m_rd_act, m_wr_buf, m_rd_buf, m_done, m_last_wr;
  bit m_pend_wr, m_pend_rd;
  int m_wr_off, m_rd_off, m_drops;

  always @(posedge Clk) if (frame_dropped === 1'b1) drop_cnt <= drop_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint base_of(input bit b);
    return b ? BUF1 : BUF0;
  endfunction

  task automatic model_reset();
    m_wr_act = 0; m_rd_act = 0; m_wr_off = 0; m_rd_off = 0;
    m_wr_buf = 0; m_rd_buf = 1; m_done = 1; m_last_wr = 0;
    m_pend_wr = 0; m_pend_rd = 0;
  endtask

  task automatic model_apply();
    // Read restart takes the completed buffer as it was before a write swap
    // that happens at the same moment.
    if (m_pend_rd) begin
      m_rd_buf = m_done; m_rd_off = 0; m_rd_act = 1; m_pend_rd = 0;
    end
    if (m_pend_wr) begin
      if (m_wr_act && m_wr_off == FRAME_BEATS) begin
        m_done = m_wr_buf; m_wr_buf = !m_wr_buf;
      end else if (m_wr_act && m_wr_off != 0) begin
        m_drops++;
      end
      m_wr_off = 0; m_wr_act = 1; m_pend_wr = 0;
    end
  endtask

  // One arbitration round: set levels/starts with grants disabled, then
  // enable and either expect one burst (served by a DDR stub) or no grant.
  task automatic step(input int wl, input int rl, input bit ws, input bit rs,
                      input int hold, input bit rst_wait);
    bit we, re, exp_wr, seen, coincide;
    longint exp_addr;
    int k;
    model_apply();
    Enable = 0;
    wr_fifo_level = LVL_W'(wl);
    rd_fifo_level = LVL_W'(rl);
    wr_frame_start = ws;
    rd_frame_start = rs;
    if (ws) m_pend_wr = 1;
    if (rs) m_pend_rd = 1;
    tick();
    wr_frame_start = 0;
    rd_frame_start = 0;
    repeat (3) tick();
    model_apply();
    check_eq("no_grant_disabled", cmd_valid, 0);
    check_eq("wr_buf_sel", wr_buf_sel, m_wr_buf);
    check_eq("rd_buf_sel", rd_buf_sel, m_rd_buf);
    check_eq("drop_count", drop_cnt, m_drops);
    we = m_wr_act && (m_wr_off < FRAME_BEATS) && (wl >= BURST_LEN);
    re = m_rd_act && (m_rd_off < FRAME_BEATS) && (rl <= RD_DEPTH - BURST_LEN);
    Enable = 1;
    txn++;
    if (!we && !re) begin
      seen = 0;
      repeat (6) begin tick(); if (cmd_valid) seen = 1; end
      check_eq("idle_no_cmd", seen, 0);
      $display("txn %0d: idle wl=%0d rl=%0d", txn, wl, rl);
      return;
    end
    if (re && rl < RD_URGENT) exp_wr = 0;
    else if (we && re) exp_wr = !m_last_wr;
    else exp_wr = we;
    exp_addr = exp_wr ? base_of(m_wr_buf) + m_wr_off : base_of(m_rd_buf) + m_rd_off;
    seen = 0;
    for (k = 0; k < 10 && !seen; k++) begin tick(); seen = cmd_valid; end
    check_eq("cmd_valid_timeout", seen, 1);
    if (!seen) return;
    check_eq("cmd_is_write", cmd_is_write, exp_wr);
    check_eq("cmd_addr", cmd_addr, exp_addr);
    $display("txn %0d: %s addr=0x%0h wl=%0d rl=%0d", txn, exp_wr ? "WR" : "RD", exp_addr, wl, rl);
    m_last_wr = exp_wr;
    for (k = 0; k < hold; k++) begin
      tick();
      check_eq("hold_valid", cmd_valid, 1);
      check_eq("hold_addr", cmd_addr, exp_addr);
    end
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    check_eq("valid_after_accept", cmd_valid, 0);
    repeat ($urandom_range(0, 4)) tick();
    if (rst_wait) begin
      Enable = 0;
      Rst_n = 0;
      tick();
      Rst_n = 1;
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_cmd_addr", cmd_addr, 0);
      model_reset();
      return;
    end
    Enable = 0;
    burst_done = 1;
    coincide = rand_starts && ($urandom_range(0, 29) == 0);
    wr_frame_start = coincide;
    if (coincide) m_pend_wr = 1;
    tick();
    burst_done = 0;
    wr_frame_start = 0;
    if (exp_wr) m_wr_off += BURST_LEN;
    else m_rd_off += BURST_LEN;
  endtask

  int wl_set[5] = '{0, 63, 64, 500, 2047};
  int rl_set[8] = '{0, 100, 127, 128, 512, 960, 961, 2047};

  initial begin
    m_drops = 0;
    model_reset();
    repeat (3) tick();
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_is_write", cmd_is_write, 0);
    check_eq("rst_addr", cmd_addr, 0);
    check_eq("rst_wr_buf", wr_buf_sel, 0);
    check_eq("rst_rd_buf", rd_buf_sel, 1);
    check_eq("rst_drop", frame_dropped, 0);
    Rst_n = 1;
    tick();

    // First write frame: addresses 0 then 64
    step(64, 2047, 1, 0, 0, 0);
    step(64, 2047, 0, 0, 2, 0);
    // Display starts: alternation W/R, reads from buffer 1
    step(200, 512, 0, 1, 1, 0);
    repeat (4) step(200, 512, 0, 0, 1, 0);
    // Urgent read right after a read grant
    step(200, 100, 0, 0, 0, 0);
    // Frame drop after 128 beats
    step(64, 2047, 1, 0, 0, 0);
    step(64, 2047, 0, 0, 0, 0);
    step(64, 2047, 1, 0, 0, 0);
    // Complete a full write frame, then swap and let the display follow
    step(64, 2047, 1, 0, 0, 0);
    repeat (FRAME_BEATS / BURST_LEN - 1) step(64, 2047, 0, 0, $urandom_range(0, 1), 0);
    step(64, 2047, 0, 0, 0, 0);
    step(0, 2047, 1, 0, 0, 0);
    step(0, 512, 0, 1, 0, 0);
    // Long stall on cmd_ready, then reset while waiting for burst_done
    step(64, 2047, 0, 0, 10, 0);
    step(64, 2047, 0, 0, 0, 1);
    step(64, 2047, 1, 0, 0, 0);
    step(64, 512, 0, 1, 0, 0);

    // Randomized traffic
    rand_starts = 1;
    repeat (400) begin
      step(wl_set[$urandom_range(0, 4)], rl_set[$urandom_range(0, 7)],
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0),
           $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_frame_arbiter.md
Name: ddr_frame_arbiter

Overview:
- Shares one DDR3 burst command port between two requesters: camera write FIFO (RAW/RGB frames in) and TFT read FIFO (display frames out).
- Decides which side gets the next burst and generates burst addresses.
- Manages two ping-pong frame buffers so the display always reads the last fully written frame.
- Sits between the capture/RAW2RGB pipeline FIFOs and the DDR3 user-interface command adapter.

Parameters:
ADDR_W, 28, width of cmd_addr (units of memory beats)
LVL_W, 11, width of FIFO level inputs
BURST_LEN, 64, beats per burst, power of two
RD_FIFO_DEPTH, 1024, depth of display FIFO in beats
RD_URGENT, 128, rd_fifo_level below this gives read absolute priority
FRAME_BEATS, 16320, beats per frame, must be a multiple of BURST_LEN
BUF0_BASE, 0, base address of buffer 0
BUF1_BASE, 'h100000, base address of buffer 1

Ports:
Clk  in  1  system clock
Rst_n  in  1  synchronous active-low reset
Enable  in  1  allow new grants
wr_frame_start  in  1  one-cycle pulse, camera VS
wr_fifo_level  in  LVL_W  beats available in write FIFO
rd_frame_start  in  1  one-cycle pulse, display VS
rd_fifo_level  in  LVL_W  beats occupied in read FIFO
cmd_valid  out  1  burst command valid
cmd_ready  in  1  command accepted when valid&ready
cmd_is_write  out  1  1 = write burst, 0 = read burst
cmd_addr  out  ADDR_W  burst start address
burst_done  in  1  pulse: last data beat of current burst transferred
wr_buf_sel  out  1  buffer being written
rd_buf_sel  out  1  buffer being read
frame_dropped  out  1  one-cycle pulse: write frame restarted before completion

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - Outputs: cmd_valid=0, cmd_is_write=0, cmd_addr=0, wr_buf_sel=0, rd_buf_sel=1, frame_dropped=0.
  - Internal: wr/rd offsets=0, wr_active=rd_active=0, done_buf=1, last_grant=read, pending starts cleared.
  - Reset mid-burst abandons the command immediately; cmd_valid drops the cycle after.
- Frame start (wr_frame_start / rd_frame_start):
  - Each pulse sets a pending flag.
  - Pending flags are applied only in ARB, never during CMD/WAIT.
- Applying a write start:
  - If wr_active and wr_offset==FRAME_BEATS: done_buf<=wr_buf_sel, wr_buf_sel toggles.
  - Else if wr_active and offset nonzero: frame_dropped pulses and the buffer is kept.
  - Then wr_offset<=0, wr_active<=1.
- Applying a read start: rd_buf_sel<=done_buf, rd_offset<=0, rd_active<=1.
- Eligibility:
  - Write eligible: wr_active, wr_offset<FRAME_BEATS, wr_fifo_level>=BURST_LEN.
  - Read eligible: rd_active, rd_offset<FRAME_BEATS, rd_fifo_level<=RD_FIFO_DEPTH-BURST_LEN.
- FSM states: ARB, CMD, WAIT.
- ARB:
  - Apply pending starts first; no grant in that cycle.
  - Otherwise, if Enable and any side is eligible, grant:
    - Read wins if eligible and rd_fifo_level<RD_URGENT.
    - Else if both eligible, the side not equal to last_grant wins.
    - Else the single eligible side wins.
  - On grant: latch cmd_is_write; latch cmd_addr = base(buf_sel) + offset; set last_grant; go to CMD.
  - Decision to cmd_valid latency is 1 cycle.
- CMD:
  - cmd_valid=1; cmd_addr and cmd_is_write are held stable until cmd_ready.
  - On valid&ready, go to WAIT with cmd_valid=0 next cycle.
- WAIT:
  - On burst_done, the granted side's offset += BURST_LEN; go to ARB.
  - burst_done in any other state is ignored.
- Frame start in the same cycle as burst_done: the offset is advanced first, then the start is applied in the following ARB.
- Enable deassert: the current burst completes normally; afterwards the FSM stays in ARB with no grants; pending starts are still applied.
- A read that reaches FRAME_BEATS stays idle until the next rd_frame_start; the same applies to writes.
- Widths: offsets are ADDR_W bits; adds are unsigned without wrap (bounded by FRAME_BEATS).

Decomposition:
- Shared package ddr_arb_pkg holds:
  - state encoding (ARB/CMD/WAIT)
  - grant encoding (GNT_RD=0, GNT_WR=1)
  - the buffer-base function
- One natural sub-module, frame_addr_gen, instanced twice (write/read). It holds offset, active, pending start and eligibility, and exposes the address.

Test Plan:
- Reset then wr_frame_start, wr_fifo_level=64, Enable=1 -> cmd_valid 2 cycles later, cmd_is_write=1, cmd_addr=0; after burst_done the next write is at addr 64.
- Both eligible, rd_fifo_level=512 -> grants alternate W,R,W,R; read addresses start at BUF1_BASE, since rd_buf_sel=1 before any completed frame.
- Read urgent: rd_fifo_level=100 and write eligible, last_grant=read -> read granted.
- Complete a 16320-beat write frame, then wr_frame_start and rd_frame_start -> wr_buf_sel=1, rd_buf_sel=0, first read addr=0.
- wr_frame_start after 128 beats written -> frame_dropped pulses once, wr_buf_sel unchanged, next write addr = base of the same buffer.
- Hold cmd_ready=0 for 10 cycles -> cmd_valid/cmd_addr stable. Assert Rst_n=0 during WAIT -> cmd_valid=0, addresses restart from 0.
